// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command decoder and register file.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam int unsigned CMD_WR_BIT      = 7;
    localparam logic [7:0]  ID_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned LED_REG_ADDR    = 0;

endpackage

// File: rtl/spi_reg_file.sv
// NREG x 8 register storage: synchronous write, asynchronous read, top address read-only.
module spi_reg_file
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [7:0]        ro_data,
    output logic [7:0]        rdata_c,
    output logic [7:0]        reg0
);

    localparam int unsigned       NREG    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(NREG - 1);

    logic [7:0] mem [NREG];

    // The top address is backed by an external counter, so writes there are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: 8'h00};
        end else if (we && (waddr != RO_ADDR)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = (raddr == RO_ADDR) ? ro_data : mem[raddr];
    assign reg0    = mem[ADDR_W'(LED_REG_ADDR)];

endmodule

// File: rtl/spi_reg_bank.sv
// Byte-level SPI command decoder: burst read/write into a register file,
// with a read-only frame counter in the top register.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  ID_BYTE = ID_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       led,
    output logic [7:0] ctrl_reg,
    output logic       busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc_c;
    logic [ADDR_W-1:0] raddr_c;
    logic [7:0]        tx_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              seen_q, seen_d;
    logic              cs_prev_q;
    logic              we_c;
    logic [7:0]        rdata_c;
    logic [7:0]        reg0;

    assign addr_inc_c = addr_q + ADDR_W'(1);

    spi_reg_file #(
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_c),
        .waddr   (addr_q),
        .wdata   (rx_byte),
        .raddr   (raddr_c),
        .ro_data (frame_cnt_q),
        .rdata_c (rdata_c),
        .reg0    (reg0)
    );

    // cs_prev resets high so a frame already active at reset release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tx_byte     <= 8'h00;
            frame_cnt_q <= 8'h00;
            seen_q      <= 1'b0;
            cs_prev_q   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tx_byte     <= tx_d;
            frame_cnt_q <= frame_cnt_d;
            seen_q      <= seen_d;
            cs_prev_q   <= cs_active;
            busy        <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tx_d        = tx_byte;
        frame_cnt_d = frame_cnt_q;
        seen_d      = seen_q;
        we_c        = 1'b0;
        raddr_c     = addr_inc_c;

        case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (cs_active && !cs_prev_q) begin
                    state_d = CMD;
                    tx_d    = ID_BYTE;
                end
            end
            CMD: begin
                raddr_c = rx_byte[ADDR_W-1:0];
                if (rx_valid) begin
                    addr_d = rx_byte[ADDR_W-1:0];
                    if (rx_byte[CMD_WR_BIT]) begin
                        state_d = WR;
                        tx_d    = ID_BYTE;
                    end else begin
                        state_d = RD;
                        tx_d    = rdata_c;
                    end
                end
            end
            WR: begin
                if (rx_valid) begin
                    we_c   = 1'b1;
                    addr_d = addr_inc_c;
                    tx_d   = ID_BYTE;
                end
            end
            RD: begin
                if (rx_valid) begin
                    addr_d = addr_inc_c;
                    tx_d   = rdata_c;
                end
            end
            default: state_d = IDLE;
        endcase

        // A strobe coincident with the CS fall is still processed above, then the frame closes.
        if (state_q != IDLE) begin
            if (rx_valid) begin
                seen_d = 1'b1;
            end
            if (!cs_active) begin
                state_d = IDLE;
                tx_d    = 8'h00;
                if (seen_q || rx_valid) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign ctrl_reg = reg0;
    assign led      = reg0[0];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: fixed vector table, corner sequences, random frames.
module tb_spi_reg_bank;

    localparam int OP_RISE = 0;
    localparam int OP_BYTE = 1;
    localparam int OP_FALL = 2;

    typedef struct {
        int         op;
        logic [7:0] data;
        logic [7:0] exp_tx;
        logic [7:0] exp_ctrl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] tx_byte;
    logic [7:0] ctrl_reg;
    logic       led;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_reg_bank #(
        .ADDR_W  (4),
        .ID_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_active (cs_active),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .led       (led),
        .ctrl_reg  (ctrl_reg),
        .busy      (busy)
    );

    // Frame-level reference: register contents, frame count, and position within the burst.
    logic [7:0] mref [16];
    logic [7:0] fc;
    int         bidx;
    bit         wr;
    int         maddr;
    logic [7:0] exp_tx;
    bit         in_frame;

    function automatic logic [7:0] mread(input int a);
        return (a == 15) ? fc : mref[a];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mref[i] = 8'h00;
        fc       = 8'h00;
        bidx     = 0;
        wr       = 1'b0;
        maddr    = 0;
        exp_tx   = 8'h00;
        in_frame = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (bidx == 0) begin
            maddr  = int'(b[3:0]);
            wr     = b[7];
            exp_tx = wr ? 8'hA5 : mread(maddr);
        end else if (wr) begin
            if (maddr != 15) mref[maddr] = b;
            maddr  = (maddr + 1) % 16;
            exp_tx = 8'hA5;
        end else begin
            maddr  = (maddr + 1) % 16;
            exp_tx = mread(maddr);
        end
        bidx++;
    endtask

    task automatic model_end();
        if (bidx > 0) fc = fc + 8'd1;
        in_frame = 1'b0;
        exp_tx   = 8'h00;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] r0;
        r0 = mref[0];
        check({tag, " tx"}, tx_byte, exp_tx);
        check({tag, " ctrl"}, ctrl_reg, r0);
        check({tag, " led"}, 8'(led), 8'(r0[0]));
        check({tag, " busy"}, 8'(busy), 8'(in_frame));
    endtask

    task automatic cs_rise();
        cs_active = 1'b1;
        step();
        in_frame = 1'b1;
        bidx     = 0;
        exp_tx   = 8'hA5;
        check_all("rise");
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        model_byte(b);
        check_all("byte");
        repeat (gap) step();
        if (gap > 0) check_all("hold");
    endtask

    task automatic cs_fall();
        cs_active = 1'b0;
        step();
        model_end();
        check_all("fall");
        step();
    endtask

    task automatic byte_fall(input logic [7:0] b);
        rx_valid  = 1'b1;
        rx_byte   = b;
        cs_active = 1'b0;
        step();
        rx_valid = 1'b0;
        model_byte(b);
        model_end();
        check_all("coinc");
        step();
    endtask

    task automatic spurious(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        check_all("spur");
        step();
    endtask

    vec_t tbl [28];
    int   n_bytes;
    int   kind;
    logic [7:0] rb;

    initial begin
        tbl[0]  = '{OP_RISE, 8'h00, 8'hA5, 8'h00};
        tbl[1]  = '{OP_BYTE, 8'h80, 8'hA5, 8'h00};
        tbl[2]  = '{OP_BYTE, 8'h01, 8'hA5, 8'h01};
        tbl[3]  = '{OP_BYTE, 8'h22, 8'hA5, 8'h01};
        tbl[4]  = '{OP_BYTE, 8'h33, 8'hA5, 8'h01};
        tbl[5]  = '{OP_FALL, 8'h00, 8'h00, 8'h01};
        tbl[6]  = '{OP_RISE, 8'h00, 8'hA5, 8'h01};
        tbl[7]  = '{OP_BYTE, 8'h00, 8'h01, 8'h01};
        tbl[8]  = '{OP_BYTE, 8'h00, 8'h22, 8'h01};
        tbl[9]  = '{OP_BYTE, 8'h00, 8'h33, 8'h01};
        tbl[10] = '{OP_FALL, 8'h00, 8'h00, 8'h01};
        tbl[11] = '{OP_RISE, 8'h00, 8'hA5, 8'h01};
        tbl[12] = '{OP_BYTE, 8'h8E, 8'hA5, 8'h01};
        tbl[13] = '{OP_BYTE, 8'h5E, 8'hA5, 8'h01};
        tbl[14] = '{OP_FALL, 8'h00, 8'h00, 8'h01};
        tbl[15] = '{OP_RISE, 8'h00, 8'hA5, 8'h01};
        tbl[16] = '{OP_BYTE, 8'h0E, 8'h5E, 8'h01};
        tbl[17] = '{OP_BYTE, 8'h00, 8'h03, 8'h01};
        tbl[18] = '{OP_BYTE, 8'h00, 8'h01, 8'h01};
        tbl[19] = '{OP_FALL, 8'h00, 8'h00, 8'h01};
        tbl[20] = '{OP_RISE, 8'h00, 8'hA5, 8'h01};
        tbl[21] = '{OP_BYTE, 8'h8F, 8'hA5, 8'h01};
        tbl[22] = '{OP_BYTE, 8'hFF, 8'hA5, 8'h01};
        tbl[23] = '{OP_BYTE, 8'h77, 8'hA5, 8'h77};
        tbl[24] = '{OP_FALL, 8'h00, 8'h00, 8'h77};
        tbl[25] = '{OP_RISE, 8'h00, 8'hA5, 8'h77};
        tbl[26] = '{OP_BYTE, 8'h0F, 8'h05, 8'h77};
        tbl[27] = '{OP_FALL, 8'h00, 8'h00, 8'h77};

        model_reset();
        repeat (3) step();
        check_all("reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Directed bursts with hand-computed expectations.
        for (int i = 0; i < 28; i++) begin
            case (tbl[i].op)
                OP_RISE: cs_rise();
                OP_BYTE: send_byte(tbl[i].data, 2);
                default: cs_fall();
            endcase
            check($sformatf("tbl%0d tx", i), tx_byte, tbl[i].exp_tx);
            check($sformatf("tbl%0d ctrl", i), ctrl_reg, tbl[i].exp_ctrl);
        end

        // Abort mid-byte: no strobe, so reg1 keeps its old value.
        cs_rise();
        send_byte(8'h81, 3);
        repeat (3) step();
        cs_fall();
        cs_rise();
        send_byte(8'h01, 1);
        check("abort reg1", tx_byte, 8'h22);
        cs_fall();

        // Strobe coincident with CS fall while writing addr 3.
        cs_rise();
        send_byte(8'h83, 2);
        byte_fall(8'h55);
        cs_rise();
        send_byte(8'h03, 1);
        check("coinc reg3", tx_byte, 8'h55);
        cs_fall();
        cs_rise();
        cs_fall();
        cs_rise();
        send_byte(8'h0F, 1);
        check("frame cnt", tx_byte, 8'h0A);
        cs_fall();

        // Stray strobe while idle must be ignored.
        spurious(8'h80);
        check("spur busy", 8'(busy), 8'h00);

        // Asynchronous reset mid-frame, released while CS is still asserted.
        cs_rise();
        send_byte(8'h82, 2);
        send_byte(8'h99, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async rst");
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check_all("post rst idle");
        cs_active = 1'b0;
        step();
        cs_rise();
        send_byte(8'h02, 2);
        check("post rst reg2", tx_byte, 8'h00);
        cs_fall();

        // Random frames against the reference model.
        for (int f = 0; f < 150; f++) begin
            n_bytes = $urandom_range(0, 6);
            kind    = $urandom_range(0, 9);
            if (kind == 0) spurious(8'($urandom));
            cs_rise();
            for (int k = 0; k < n_bytes; k++) begin
                rb = 8'($urandom);
                if (k == 0 && kind >= 7) rb = {rb[7], 3'b000, 4'hF};
                if (k == n_bytes - 1 && kind == 1) byte_fall(rb);
                else send_byte(rb, $urandom_range(1, 4));
            end
            if (!(n_bytes > 0 && kind == 1)) begin
                if (kind == 2) repeat (3) step();
                cs_fall();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Byte-level command decoder and register file directly downstream of SPI_slave.
- Consumes received-byte strobes and frame state, and supplies the next transmit byte back to the slave.
- Frame protocol: byte 0 is the command (bit7 = 1 write / 0 read; low ADDR_W bits = start address). Following bytes are burst data with address auto-increment.
- Register 0 drives the board LED. The top register is a read-only frame counter.

Parameters:
- ADDR_W, 4, address width; NREG = 2**ADDR_W registers, each 8 bits.
- ID_BYTE, 8'hA5, byte presented on tx_byte during every command byte.

Ports:
- clk  in  1  system clock (25 MHz); same clock as SPI_slave
- rst_n  in  1  asynchronous active-low reset
- cs_active  in  1  level; 1 while SSEL is asserted, already synchronised to clk by SPI_slave
- rx_valid  in  1  one-clk strobe; rx_byte holds a complete received byte
- rx_byte  in  8  received byte, valid only when rx_valid = 1
- tx_byte  out  8  byte the slave shifts out on the next 8 SCK cycles; held stable between updates
- led  out  1  reg[0][0]
- ctrl_reg  out  8  full contents of reg[0]
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): every reg = 0, frame_cnt = 0, state = IDLE, tx_byte = 0, led = 0, ctrl_reg = 0, busy = 0.
- States: IDLE, CMD, WR, RD.
  - IDLE: on cs_active = 1 → CMD; tx_byte <= ID_BYTE in the same transition.
  - CMD: on rx_valid, latch addr <= rx_byte[ADDR_W-1:0]. If rx_byte[7] = 1 → WR. Otherwise → RD with tx_byte <= reg[rx_byte[ADDR_W-1:0]]. rx_byte bits [6:ADDR_W] are ignored.
  - WR: on rx_valid, write reg[addr] <= rx_byte, then addr <= addr+1. tx_byte <= ID_BYTE, so MISO echoes ID during writes.
  - RD: on rx_valid, addr <= addr+1 and tx_byte <= reg[addr+1]. The rx_byte value is ignored (dummy byte).
  - Any state with cs_active = 0 → IDLE next cycle; tx_byte <= 0.
- Latency:
  - tx_byte is registered and updates exactly 1 clk after the rx_valid strobe, or after the cs_active rise.
  - A written register is visible on ctrl_reg/led 1 clk after rx_valid.
  - SPI_slave latches tx_byte at the next byte boundary, which is at least 8 clk after the strobe for SCK ≤ 3 MHz.
- Address wrap: addr increments modulo NREG (NREG-1 → 0) for both write and read bursts.
- Read-only register NREG-1 (frame_cnt):
  - Writes to it are ignored, but the address still increments.
  - Reads return frame_cnt.
  - frame_cnt increments by 1 (mod 256) on each cs_active fall when at least one rx_valid occurred in that frame. Empty frames do not count.
- Simultaneous rx_valid and cs_active = 0 in the same cycle: the byte is fully processed (write committed / addr advanced), then the block goes to IDLE. frame_cnt counts that frame.
- cs_active falling mid-byte: no strobe arrives, so nothing is written. The next frame always restarts in CMD, and addr from the previous frame is not reused.
- rx_valid while IDLE (spurious): ignored.
- Reset mid-frame: immediate return to reset values. Register contents are lost.
- cs_active rise in the same cycle as reset release: that frame is not entered. The block waits in IDLE for the next cs_active rise.

Decomposition:
- Package spi_reg_pkg holds:
  - state enum type (IDLE, CMD, WR, RD);
  - constants CMD_WR_BIT = 7 and default ID_BYTE;
  - LED_REG_ADDR = 0.
- One sub-module: spi_reg_file. It holds the NREG×8 storage, a synchronous write port, an asynchronous read port, and read-only masking of address NREG-1. The FSM, address pointer, frame counter and tx_byte register stay in spi_reg_bank.

Test Plan:
- Reset: drive rst_n = 0 mid-simulation with cs_active = 1 → all outputs 0 immediately. After release, state IDLE until a new cs_active rise.
- Write burst: frame bytes 0x80, 0x01, 0x22, 0x33 → reg0 = 01, reg1 = 22, reg2 = 33; led = 1 one clk after the second strobe; tx_byte = A5 throughout; frame_cnt = 1 after CS drop.
- Read burst with wrap: preload reg14 = 0x5E, reg0 = 0x01; send 0x0E then dummies 00, 00, 00 → tx_byte sequence A5, 5E, frame_cnt, 01.
- Read-only protect: write frame 0x8F, 0xFF, 0x77 → reg15 unchanged (still frame_cnt); reg0 = 0x77 via wrap; led = 1.
- Abort: cs_active drops 3 SCK bits into byte 2 of write frame 0x81, 0x44 with no strobe → reg1 unchanged. The next frame 0x01, 00 reads the old reg1 value.
- Edge coincidence: rx_valid = 1 with byte 0x55 in the same clk that cs_active falls during WR at addr 3 → reg3 = 0x55, state IDLE next clk, frame_cnt incremented once. An empty CS pulse afterwards leaves frame_cnt unchanged.
